alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 32-bit `alu` instance between two requesters: the EX stage at index 0 and an auxiliary address/compare unit at index 1.
- Round-robin grant with valid/ready handshakes on request and response.
- One registered result slot between the ALU and the responders, so results return exactly one cycle after grant.
- Sits between the pipe_computer EX stage and the shared ALU; replaces the direct EX-to-ALU wiring.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (the `alu` datapath is fixed at 32).
- FIRST_PRIO, 0, requester holding priority after reset (0 or 1).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  32 each  operands
- req0_aluc  in  4  ALU opcode (alu encoding)
- req1_valid, req1_ready, req1_a, req1_b, req1_aluc  same as above for requester 1
- rsp0_valid  out  1  result for requester 0 held in slot
- rsp0_ready  in  1  requester 0 consumes result
- rsp1_valid, rsp1_ready  same for requester 1
- rsp_s  out  32  slot result, shared; qualified by rspN_valid

Behaviour:
- Reset (asynchronous, active-high):
  - slot_valid=0, owner=0, prio=FIRST_PRIO.
  - All outputs 0: req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_s.
- slot_free = !slot_valid | (rsp_owner_valid & rsp_owner_ready). This is the drain-and-refill case: the slot may be refilled in the same cycle it drains.
- Grant (combinational, from registered state):
  - Only when slot_free.
  - Only valid requesters compete.
  - Both valid: the prio requester wins.
  - At most one reqN_ready high per cycle.
  - reqN_ready never rises without reqN_valid.
- Accept (reqN_valid & reqN_ready) at clock edge:
  - slot_valid<=1, owner<=N.
  - rsp_s <= alu(reqN_a, reqN_b, reqN_aluc) computed that cycle.
  - prio <= ~N. prio changes only on accept.
- Latency: result visible exactly one cycle after accept.
- rspN_valid = slot_valid & (owner==N).
- Drain with no new accept: slot_valid<=0; rsp_s holds its last value.
- Back-pressure: while the slot is full and the owner's ready is low, no grants occur, and rsp_s/owner stay stable.
- Requester protocol: reqN operands must be stable while valid and not ready. The arbiter does not latch un-granted requests.
- Starvation bound: a continuously valid requester is granted within 2 accepts.
- Reset mid-operation: the slot result is discarded and no response is issued.
- Opcode rules (defined by `alu`; passed through unchanged):
  - Shift ops use a[4:0] (the arbiter does not mask).
  - Undefined aluc yields 0.
- One state register: prio. The slot has two states, EMPTY and FULL:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or while stalled.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0 (32), gnt_cnt1 (32), conflict_cnt (32).
  - gnt_cntN counts accepts by requester N.
  - conflict_cnt counts cycles with both reqN_valid high and slot_free.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - aluc localparams: ADD 4'b0000, SUB 4'b0100, AND 4'b0001, OR 4'b0101, XOR 4'b0010, LUI 4'b0110, SLL 4'b0011, SRL 4'b0111, SRA 4'b1111, GT 4'b1011.
  - Requester index constants REQ_EX=0, REQ_AUX=1.
- Sub-module rr_pick2: combinational two-way round-robin picker (valid[1:0], prio -> grant[1:0]).
- The existing `alu` is instantiated unchanged.

Test Plan:
- Solo ADD: req0 a=5, b=7, aluc=0000, rsp0_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp0_valid=1, rsp_s=12, rsp1_valid=0.
- Contention after reset (FIRST_PRIO=0): req0 SUB 10-3 and req1 XOR 0xFF^0x0F in the same cycle -> req0 granted first, rsp_s=7 (owner 0); next cycle req1 granted, then rsp_s=0xF0 (owner 1); prio alternates.
- Back-pressure: req0 LUI b=0x1234, rsp0_ready=0 for 3 cycles with req1 valid -> rsp_s=0x12340000 held; req1_ready=0 throughout. When rsp0_ready=1, req1 is granted in that same cycle.
- Arithmetic shift: req1 SRA a=4, b=0xF0000000, aluc=1111 -> rsp1_valid, rsp_s=0xFF000000; SRL with the same operands -> 0x0F000000.
- Reset mid-operation: assert reset while slot FULL with rsp0_ready=0 -> rsp0_valid drops asynchronously. After release, no stale response; prio=FIRST_PRIO.
- ALU_ARB_STATS_EN: 5 contended cycles with both valid and all responses ready -> conflict_cnt=5, gnt_cnt0=3, gnt_cnt1=2.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, requester indices and slot state for alu_arbiter
package alu_pkg;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0100;
    localparam logic [3:0] AND = 4'b0001;
    localparam logic [3:0] OR  = 4'b0101;
    localparam logic [3:0] XOR = 4'b0010;
    localparam logic [3:0] LUI = 4'b0110;
    localparam logic [3:0] SLL = 4'b0011;
    localparam logic [3:0] SRL = 4'b0111;
    localparam logic [3:0] SRA = 4'b1111;
    localparam logic [3:0] GT  = 4'b1011;

    localparam logic REQ_EX  = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational ALU shared through alu_arbiter
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluc,
    output logic [31:0] r
);
    // Shifts take the amount from a[4:0] and shift b.
    always_comb begin
        r = 32'h0;
        case (aluc)
            ADD:     r = a + b;
            SUB:     r = a - b;
            AND:     r = a & b;
            OR:      r = a | b;
            XOR:     r = a ^ b;
            LUI:     r = {b[15:0], 16'h0000};
            SLL:     r = b << a[4:0];
            SRL:     r = b >> a[4:0];
            SRA:     r = $unsigned($signed(b) >>> a[4:0]);
            GT:      r = {31'h0, ($signed(a) > $signed(b))};
            default: r = 32'h0;
        endcase
    end
endmodule

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] & (~valid[1] | ~prio);
        grant[1] = valid[1] & (~valid[0] |  prio);
    end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin share of one ALU between EX and AUX with a one-entry result slot
// Optional grant/conflict counters under ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int   WIDTH      = 32,
    parameter logic FIRST_PRIO = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_aluc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_aluc,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_s
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]      gnt_cnt0,
    output logic [31:0]      gnt_cnt1,
    output logic [31:0]      conflict_cnt
`endif
);
    slot_state_t      slot_q, slot_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] rsp_s_q, rsp_s_d;

    logic             slot_full;
    logic             owner_ready;
    logic             slot_free;
    logic [1:0]       pick;
    logic [1:0]       gnt;
    logic             accept;
    logic             acc_idx;
    logic [WIDTH-1:0] op_a, op_b, alu_r;
    logic [3:0]       op_c;

    assign slot_full   = (slot_q == SLOT_FULL);
    assign owner_ready = (owner_q == REQ_AUX) ? rsp1_ready : rsp0_ready;
    // A draining slot can be refilled in the same cycle.
    assign slot_free   = ~slot_full | owner_ready;

    rr_pick2 u_pick (
        .valid ({req1_valid, req0_valid}),
        .prio  (prio_q),
        .grant (pick)
    );

    assign gnt        = (slot_free & ~reset) ? pick : 2'b00;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;
    assign acc_idx    = gnt[1];

    assign op_a = acc_idx ? req1_a    : req0_a;
    assign op_b = acc_idx ? req1_b    : req0_b;
    assign op_c = acc_idx ? req1_aluc : req0_aluc;

    alu u_alu (
        .a    (op_a),
        .b    (op_b),
        .aluc (op_c),
        .r    (alu_r)
    );

    always_comb begin
        slot_d  = slot_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        rsp_s_d = rsp_s_q;
        case (slot_q)
            SLOT_EMPTY: if (accept) slot_d = SLOT_FULL;
            SLOT_FULL: begin
                if (accept)           slot_d = SLOT_FULL;
                else if (owner_ready) slot_d = SLOT_EMPTY;
            end
            default: slot_d = SLOT_EMPTY;
        endcase
        if (accept) begin
            owner_d = acc_idx;
            prio_d  = ~acc_idx;
            rsp_s_d = alu_r;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q  <= SLOT_EMPTY;
            owner_q <= REQ_EX;
            prio_q  <= FIRST_PRIO;
            rsp_s_q <= '0;
        end else begin
            slot_q  <= slot_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            rsp_s_q <= rsp_s_d;
        end
    end

    assign rsp0_valid = slot_full & (owner_q == REQ_EX);
    assign rsp1_valid = slot_full & (owner_q == REQ_AUX);
    assign rsp_s      = rsp_s_q;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [31:0] gnt_cnt1_q, gnt_cnt1_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        gnt_cnt0_d     = gnt_cnt0_q;
        gnt_cnt1_d     = gnt_cnt1_q;
        conflict_cnt_d = conflict_cnt_q;
        if (gnt[0] && gnt_cnt0_q != 32'hFFFF_FFFF)
            gnt_cnt0_d = gnt_cnt0_q + 32'd1;
        if (gnt[1] && gnt_cnt1_q != 32'hFFFF_FFFF)
            gnt_cnt1_d = gnt_cnt1_q + 32'd1;
        if (req0_valid && req1_valid && slot_free && conflict_cnt_q != 32'hFFFF_FFFF)
            conflict_cnt_d = conflict_cnt_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            gnt_cnt0_q     <= gnt_cnt0_d;
            gnt_cnt1_q     <= gnt_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign gnt_cnt0     = gnt_cnt0_q;
    assign gnt_cnt1     = gnt_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a reference model
module tb_alu_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_aluc, req1_aluc;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_s;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_arbiter #(.WIDTH(32), .FIRST_PRIO(1'b0)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_aluc  (req0_aluc),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_aluc  (req1_aluc),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_s      (rsp_s)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt_cnt0     (gnt_cnt0),
        .gnt_cnt1     (gnt_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        longint sb;
        int sh;
        sh = int'(a % 32);
        sb = longint'($signed(b));
        case (op)
            4'b0000: return a + b;
            4'b0100: return a - b;
            4'b0001: return a & b;
            4'b0101: return a | b;
            4'b0010: return a ^ b;
            4'b0110: return b * 32'h10000;
            4'b0011: return b * (32'd1 << sh);
            4'b0111: return b / (32'd1 << sh);
            4'b1111: return 32'(sb >>> sh);
            4'b1011: return (int'(a) > int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_aluc = 0;
        req1_a = 0; req1_b = 0; req1_aluc = 0;
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_valid = 1; req1_valid = 1;
        reset = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        checks++;
        if (rsp_s !== 32'h0) begin errors++; $display("FAIL reset_rsp_s got %h want 0", rsp_s); end
        @(negedge clock);
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_solo_add();
        do_reset();
        @(negedge clock);
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_aluc = 4'b0000; rsp0_ready = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL solo_ready got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clock);
        req0_valid = 0;
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errors++; $display("FAIL solo_rsp_valid got %b want 10", {rsp0_valid, rsp1_valid}); end
        checks++;
        if (rsp_s !== 32'd12) begin errors++; $display("FAIL solo_rsp_s got %h want 0000000c", rsp_s); end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clock);
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 10; req0_b = 3; req0_aluc = 4'b0100;
        req1_valid = 1; req1_a = 32'hFF; req1_b = 32'h0F; req1_aluc = 4'b0010;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_first got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clock);
        req0_valid = 0;
        #1;
        checks++;
        if ({rsp0_valid, rsp_s} !== {1'b1, 32'd7}) begin errors++; $display("FAIL cont_rsp0 got %b/%h want 1/00000007", rsp0_valid, rsp_s); end
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL cont_second got %b want 1", req1_ready); end
        @(negedge clock);
        req1_valid = 0;
        #1;
        checks++;
        if ({rsp1_valid, rsp0_valid, rsp_s} !== {2'b10, 32'hF0}) begin errors++; $display("FAIL cont_rsp1 got %b%b/%h want 10/000000f0", rsp1_valid, rsp0_valid, rsp_s); end
        @(negedge clock);
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_alt0 got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clock);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL cont_alt1 got %b want 01", {req0_ready, req1_ready}); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_back_pressure();
        do_reset();
        @(negedge clock);
        req0_valid = 1; req0_b = 32'h1234; req0_aluc = 4'b0110; rsp0_ready = 0;
        req1_valid = 1; req1_a = 1; req1_b = 1; req1_aluc = 4'b0000; rsp1_ready = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL bp_grant got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clock);
        req0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++;
            if ({rsp0_valid, req1_ready, rsp_s} !== {2'b10, 32'h1234_0000}) begin
                errors++;
                $display("FAIL bp_hold%0d got %b%b/%h want 10/12340000", i, rsp0_valid, req1_ready, rsp_s);
            end
        end
        @(negedge clock);
        rsp0_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", req1_ready); end
        @(negedge clock);
        req1_valid = 0;
        #1;
        checks++;
        if ({rsp1_valid, rsp_s} !== {1'b1, 32'd2}) begin errors++; $display("FAIL bp_rsp1 got %b/%h want 1/00000002", rsp1_valid, rsp_s); end
    endtask

    task automatic test_shift();
        do_reset();
        @(negedge clock);
        rsp1_ready = 1;
        req1_valid = 1; req1_a = 4; req1_b = 32'hF000_0000; req1_aluc = 4'b1111;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL sra_grant got %b want 1", req1_ready); end
        @(negedge clock);
        req1_aluc = 4'b0111;
        #1;
        checks++;
        if ({rsp1_valid, rsp_s} !== {1'b1, 32'hFF00_0000}) begin errors++; $display("FAIL sra_rsp got %b/%h want 1/ff000000", rsp1_valid, rsp_s); end
        @(negedge clock);
        req1_valid = 0;
        #1;
        checks++;
        if ({rsp1_valid, rsp_s} !== {1'b1, 32'h0F00_0000}) begin errors++; $display("FAIL srl_rsp got %b/%h want 1/0f000000", rsp1_valid, rsp_s); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clock);
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_aluc = 4'b0000; rsp0_ready = 0;
        @(negedge clock);
        req0_valid = 0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL rmid_full got %b want 1", rsp0_valid); end
        #1;
        reset = 1;
        #1;
        checks++;
        if ({rsp0_valid, rsp_s} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rmid_async got %b/%h want 0/00000000", rsp0_valid, rsp_s); end
        @(negedge clock);
        reset = 0;
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL rmid_stale got %b want 00", {rsp0_valid, rsp1_valid}); end
        @(negedge clock);
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rmid_prio got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_random();
        bit          m_full;
        bit          m_owner;
        bit          m_prio;
        logic [31:0] m_res;
        bit          hold0, hold1;
        bit          free, g0, g1;
        int          wait0, wait1;
        do_reset();
        m_full = 0; m_owner = 0; m_prio = 0; m_res = 0;
        hold0 = 0; hold1 = 0; wait0 = 0; wait1 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (!hold0) begin
                req0_valid = ($urandom_range(0, 9) < 7);
                req0_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                req0_b = $urandom;
                req0_aluc = 4'($urandom_range(0, 15));
            end
            if (!hold1) begin
                req1_valid = ($urandom_range(0, 9) < 7);
                req1_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                req1_b = $urandom;
                req1_aluc = 4'($urandom_range(0, 15));
            end
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            #1;
            free = !m_full || (m_owner ? rsp1_ready : rsp0_ready);
            g0 = free && req0_valid && (!req1_valid || m_prio == 0);
            g1 = free && req1_valid && (!req0_valid || m_prio == 1);
            checks++;
            if ({req0_ready, req1_ready} !== {g0, g1}) begin
                errors++;
                $display("FAIL rand_ready cyc %0d got %b want %b", cyc, {req0_ready, req1_ready}, {g0, g1});
            end
            checks++;
            if ({rsp0_valid, rsp1_valid} !== {m_full && !m_owner, m_full && m_owner}) begin
                errors++;
                $display("FAIL rand_rsp_valid cyc %0d got %b want %b", cyc, {rsp0_valid, rsp1_valid}, {m_full && !m_owner, m_full && m_owner});
            end
            checks++;
            if (rsp_s !== m_res) begin
                errors++;
                $display("FAIL rand_rsp_s cyc %0d got %h want %h", cyc, rsp_s, m_res);
            end
            if (g0) begin
                checks++;
                if (wait0 > 1) begin errors++; $display("FAIL rand_starve0 cyc %0d got %0d want <=1", cyc, wait0); end
            end
            if (g1) begin
                checks++;
                if (wait1 > 1) begin errors++; $display("FAIL rand_starve1 cyc %0d got %0d want <=1", cyc, wait1); end
            end
            wait0 = (req0_valid && !g0) ? wait0 + int'(g1) : 0;
            wait1 = (req1_valid && !g1) ? wait1 + int'(g0) : 0;
            hold0 = req0_valid && !g0;
            hold1 = req1_valid && !g1;
            if (g0 || g1) begin
                m_full  = 1;
                m_owner = g1;
                m_prio  = !g1;
                m_res   = g1 ? ref_alu(req1_a, req1_b, req1_aluc) : ref_alu(req0_a, req0_b, req0_aluc);
            end else if (free) begin
                m_full = 0;
            end
        end
        @(negedge clock);
        idle_inputs();
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clock);
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req1_valid = 1;
        repeat (5) @(negedge clock);
        req0_valid = 0; req1_valid = 0;
        @(negedge clock);
        #1;
        checks++;
        if (conflict_cnt !== 32'd5) begin errors++; $display("FAIL stats_conflict got %0d want 5", conflict_cnt); end
        checks++;
        if (gnt_cnt0 !== 32'd3) begin errors++; $display("FAIL stats_gnt0 got %0d want 3", gnt_cnt0); end
        checks++;
        if (gnt_cnt1 !== 32'd2) begin errors++; $display("FAIL stats_gnt1 got %0d want 2", gnt_cnt1); end
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 0;
        test_reset();
        test_solo_add();
        test_contention();
        test_back_pressure();
        test_shift();
        test_reset_mid();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
